// File: rtl/vp_pkg.sv
// Shared widths, switch bit positions, accumulator reload values and the
// channel-select helper for the bounding-box video processor.
package vp_pkg;

  localparam int PIX_W_D = 8;
  localparam int CH_D    = 3;
  localparam int X_W_D   = 11;
  localparam int Y_W_D   = 11;

  localparam int SW_OVL    = 2;
  localparam int SW_CH_LSB = 0;

  // Upper bounds for the generic channel-select helper.
  localparam int PIX_W_MAX = 16;
  localparam int CH_MAX    = 4;
  localparam int BUS_MAX   = PIX_W_MAX * CH_MAX;

  localparam bit ACC_MIN_FILL = 1'b1;
  localparam bit ACC_MAX_FILL = 1'b0;
  localparam bit ACC_ANY_RST  = 1'b0;

  // Channel 0 sits in the MSBs; selections past the last channel clamp to it.
  function automatic logic [PIX_W_MAX-1:0] ch_sel(input logic [BUS_MAX-1:0] pixel,
                                                  input logic [1:0]         sel,
                                                  input int                 ch,
                                                  input int                 pw);
    int                 idx;
    logic [BUS_MAX-1:0] field_mask;
    idx        = (int'(sel) >= ch) ? ch - 1 : int'(sel);
    field_mask = ~({BUS_MAX{1'b1}} << pw);
    return PIX_W_MAX'((pixel >> ((ch - 1 - idx) * pw)) & field_mask);
  endfunction

endpackage

// File: rtl/vp_sync_delay.sv
// Fixed-length register pipeline used to keep syncs and pixel data aligned.
module vp_sync_delay #(
  parameter int N = 2,
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] pipe_q [N];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= d_i;
      for (int i = 1; i < N; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign q_o = pipe_q[N-1];

endmodule

// File: rtl/vp_bbox.sv
// Threshold one colour channel, track the per-frame foreground bounding box and
// optionally outline the previous box on the video. Macro: VP_BBOX_CENTROID_EN.
module vp_bbox
  import vp_pkg::*;
#(
  parameter int PIX_W = PIX_W_D,
  parameter int CH    = CH_D,
  parameter int X_W   = X_W_D,
  parameter int Y_W   = Y_W_D,
  parameter logic [CH*PIX_W-1:0] OVL_COLOR = {CH{{PIX_W{1'b1}}}}
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 de_in,
  input  logic                 h_sync_in,
  input  logic                 v_sync_in,
  input  logic [CH*PIX_W-1:0]  pixel_in,
  input  logic [2:0]           sw,
  input  logic [PIX_W-1:0]     thr,
  output logic                 de_out,
  output logic                 h_sync_out,
  output logic                 v_sync_out,
  output logic [CH*PIX_W-1:0]  pixel_out,
  output logic [X_W-1:0]       x_min,
  output logic [X_W-1:0]       x_max,
  output logic [Y_W-1:0]       y_min,
  output logic [Y_W-1:0]       y_max,
  output logic                 bbox_empty,
`ifdef VP_BBOX_CENTROID_EN
  output logic [X_W-1:0]       cx,
  output logic [Y_W-1:0]       cy,
`endif
  output logic                 bbox_valid
);

  localparam int PW = CH * PIX_W;
  localparam logic [X_W-1:0] X_SAT = '1;
  localparam logic [Y_W-1:0] Y_SAT = '1;

  logic                 de_q, vs_q;
  logic [X_W-1:0]       x_q, x_d, px_x_q;
  logic [Y_W-1:0]       y_q, y_d, px_y_q;
  logic [X_W-1:0]       acc_xmin_q, acc_xmin_d, acc_xmax_q, acc_xmax_d;
  logic [Y_W-1:0]       acc_ymin_q, acc_ymin_d, acc_ymax_q, acc_ymax_d;
  logic                 any_q, any_d, armed_q, armed_d;
  logic [X_W-1:0]       x_min_q, x_min_d, x_max_q, x_max_d;
  logic [Y_W-1:0]       y_min_q, y_min_d, y_max_q, y_max_d;
  logic                 empty_q, empty_d, valid_q, valid_d;
  logic [PW-1:0]        pix_s1, pix_out_q, pix_out_d;
  logic [PIX_W_MAX-1:0] chan;
  logic                 de_fall, vs_rise, mask;
  logic                 in_x, in_y, ovl_hit;
`ifdef VP_BBOX_CENTROID_EN
  logic [X_W:0]         sum_x;
  logic [Y_W:0]         sum_y;
  logic [X_W-1:0]       cx_q, cx_d;
  logic [Y_W-1:0]       cy_q, cy_d;
`endif

  vp_sync_delay #(.N(2), .W(3)) u_sync_dly (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   ({de_in, h_sync_in, v_sync_in}),
    .q_o   ({de_out, h_sync_out, v_sync_out})
  );

  vp_sync_delay #(.N(1), .W(PW)) u_pix_dly (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (pixel_in),
    .q_o   (pix_s1)
  );

  assign chan    = ch_sel(BUS_MAX'(pixel_in), sw[SW_CH_LSB +: 2], CH, PIX_W);
  assign mask    = de_in & (chan >= PIX_W_MAX'(thr));
  assign de_fall = de_q & ~de_in;
  assign vs_rise = v_sync_in & ~vs_q;

`ifdef VP_BBOX_CENTROID_EN
  assign sum_x = {1'b0, acc_xmin_q} + {1'b0, acc_xmax_q};
  assign sum_y = {1'b0, acc_ymin_q} + {1'b0, acc_ymax_q};
`endif

  always_comb begin
    x_d        = x_q;
    y_d        = y_q;
    acc_xmin_d = acc_xmin_q;
    acc_xmax_d = acc_xmax_q;
    acc_ymin_d = acc_ymin_q;
    acc_ymax_d = acc_ymax_q;
    any_d      = any_q;
    x_min_d    = x_min_q;
    x_max_d    = x_max_q;
    y_min_d    = y_min_q;
    y_max_d    = y_max_q;
    empty_d    = empty_q;
    valid_d    = 1'b0;
    armed_d    = armed_q | vs_rise;
`ifdef VP_BBOX_CENTROID_EN
    cx_d       = cx_q;
    cy_d       = cy_q;
`endif

    if (de_in) begin
      if (x_q != X_SAT) x_d = x_q + 1'b1;
    end else if (de_fall) begin
      x_d = '0;
    end

    if (vs_rise) begin
      y_d = '0;
    end else if (de_fall && (y_q != Y_SAT)) begin
      y_d = y_q + 1'b1;
    end

    // The frame-close reload takes priority over a coincident foreground pixel.
    if (vs_rise) begin
      acc_xmin_d = {X_W{ACC_MIN_FILL}};
      acc_xmax_d = {X_W{ACC_MAX_FILL}};
      acc_ymin_d = {Y_W{ACC_MIN_FILL}};
      acc_ymax_d = {Y_W{ACC_MAX_FILL}};
      any_d      = ACC_ANY_RST;
    end else if (mask) begin
      if (x_q < acc_xmin_q) acc_xmin_d = x_q;
      if (x_q > acc_xmax_q) acc_xmax_d = x_q;
      if (y_q < acc_ymin_q) acc_ymin_d = y_q;
      if (y_q > acc_ymax_q) acc_ymax_d = y_q;
      any_d = 1'b1;
    end

    if (vs_rise && armed_q) begin
      valid_d = 1'b1;
      empty_d = ~any_q;
      x_min_d = any_q ? acc_xmin_q : '0;
      x_max_d = any_q ? acc_xmax_q : '0;
      y_min_d = any_q ? acc_ymin_q : '0;
      y_max_d = any_q ? acc_ymax_q : '0;
`ifdef VP_BBOX_CENTROID_EN
      cx_d    = any_q ? sum_x[X_W:1] : '0;
      cy_d    = any_q ? sum_y[Y_W:1] : '0;
`endif
    end
  end

  // Stage 2: outline the previously latched box on the passing pixel.
  always_comb begin
    in_x    = (px_x_q >= x_min_q) && (px_x_q <= x_max_q);
    in_y    = (px_y_q >= y_min_q) && (px_y_q <= y_max_q);
    ovl_hit = (((px_x_q == x_min_q) || (px_x_q == x_max_q)) && in_y) ||
              (((px_y_q == y_min_q) || (px_y_q == y_max_q)) && in_x);
`ifdef VP_BBOX_CENTROID_EN
    ovl_hit = ovl_hit || (in_x && in_y && ((px_x_q == cx_q) || (px_y_q == cy_q)));
`endif
    pix_out_d = (sw[SW_OVL] && !empty_q && de_q && ovl_hit) ? OVL_COLOR : pix_s1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      de_q       <= 1'b0;
      vs_q       <= 1'b0;
      x_q        <= '0;
      y_q        <= '0;
      px_x_q     <= '0;
      px_y_q     <= '0;
      acc_xmin_q <= {X_W{ACC_MIN_FILL}};
      acc_xmax_q <= {X_W{ACC_MAX_FILL}};
      acc_ymin_q <= {Y_W{ACC_MIN_FILL}};
      acc_ymax_q <= {Y_W{ACC_MAX_FILL}};
      any_q      <= ACC_ANY_RST;
      armed_q    <= 1'b0;
      x_min_q    <= '0;
      x_max_q    <= '0;
      y_min_q    <= '0;
      y_max_q    <= '0;
      empty_q    <= 1'b1;
      valid_q    <= 1'b0;
      pix_out_q  <= '0;
`ifdef VP_BBOX_CENTROID_EN
      cx_q       <= '0;
      cy_q       <= '0;
`endif
    end else begin
      de_q       <= de_in;
      vs_q       <= v_sync_in;
      x_q        <= x_d;
      y_q        <= y_d;
      px_x_q     <= x_q;
      px_y_q     <= y_q;
      acc_xmin_q <= acc_xmin_d;
      acc_xmax_q <= acc_xmax_d;
      acc_ymin_q <= acc_ymin_d;
      acc_ymax_q <= acc_ymax_d;
      any_q      <= any_d;
      armed_q    <= armed_d;
      x_min_q    <= x_min_d;
      x_max_q    <= x_max_d;
      y_min_q    <= y_min_d;
      y_max_q    <= y_max_d;
      empty_q    <= empty_d;
      valid_q    <= valid_d;
      pix_out_q  <= pix_out_d;
`ifdef VP_BBOX_CENTROID_EN
      cx_q       <= cx_d;
      cy_q       <= cy_d;
`endif
    end
  end

  assign pixel_out  = pix_out_q;
  assign x_min      = x_min_q;
  assign x_max      = x_max_q;
  assign y_min      = y_min_q;
  assign y_max      = y_max_q;
  assign bbox_empty = empty_q;
  assign bbox_valid = valid_q;
`ifdef VP_BBOX_CENTROID_EN
  assign cx         = cx_q;
  assign cy         = cy_q;
`endif

endmodule

// File: tb/tb_vp_bbox.sv
// Directed bench for vp_bbox: frame sequences with known foreground pixels,
// box/empty/valid checks at each frame close and a 2-cycle pipeline model.
module tb_vp_bbox;

  localparam logic [23:0] OVL   = 24'hFFFFFF;
  localparam logic [23:0] BLANK = 24'h0F0F0F;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        de_in = 1'b0, h_sync_in = 1'b0, v_sync_in = 1'b0;
  logic [23:0] pixel_in = '0;
  logic [2:0]  sw = '0;
  logic [7:0]  thr = '0;
  logic        de_out, h_sync_out, v_sync_out, bbox_empty, bbox_valid;
  logic [23:0] pixel_out;
  logic [10:0] x_min, x_max, y_min, y_max;
`ifdef VP_BBOX_CENTROID_EN
  logic [10:0] cx, cy;
`endif

  vp_bbox dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .de_in      (de_in),
    .h_sync_in  (h_sync_in),
    .v_sync_in  (v_sync_in),
    .pixel_in   (pixel_in),
    .sw         (sw),
    .thr        (thr),
    .de_out     (de_out),
    .h_sync_out (h_sync_out),
    .v_sync_out (v_sync_out),
    .pixel_out  (pixel_out),
    .x_min      (x_min),
    .x_max      (x_max),
    .y_min      (y_min),
    .y_max      (y_max),
    .bbox_empty (bbox_empty),
`ifdef VP_BBOX_CENTROID_EN
    .cx         (cx),
    .cy         (cy),
`endif
    .bbox_valid (bbox_valid)
  );

  always #5 clk = ~clk;

  int     checks = 0, errors = 0, valid_cnt = 0;
  longint s_xmin, s_xmax, s_ymin, s_ymax, s_empty, s_cx, s_cy;
  bit     pipe_on = 0, prev_ok = 0, ovl_model = 0;
  logic   prev_de, prev_hs, prev_vs;
  logic [23:0] prev_exp;
  int     mx0 = 2, mx1 = 10, my0 = 1, my1 = 6, mcx = 6, mcy = 3;

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive one cycle, then check the outputs against the inputs of the previous call.
  task automatic drive(input logic d, input logic h, input logic v,
                       input logic [23:0] p, input logic [23:0] e);
    de_in = d; h_sync_in = h; v_sync_in = v; pixel_in = p;
    @(posedge clk); #1;
    if (bbox_valid === 1'b1) begin
      valid_cnt++;
      s_xmin = x_min; s_xmax = x_max; s_ymin = y_min; s_ymax = y_max; s_empty = bbox_empty;
`ifdef VP_BBOX_CENTROID_EN
      s_cx = cx; s_cy = cy;
`else
      s_cx = 0; s_cy = 0;
`endif
    end
    if (pipe_on && prev_ok) begin
      checks++;
      assert ({de_out, h_sync_out, v_sync_out, pixel_out} === {prev_de, prev_hs, prev_vs, prev_exp}) else begin
        errors++;
        $error("FAIL pipe: observed %h expected %h",
               {de_out, h_sync_out, v_sync_out, pixel_out}, {prev_de, prev_hs, prev_vs, prev_exp});
      end
    end
    prev_de = d; prev_hs = h; prev_vs = v; prev_exp = e; prev_ok = 1;
  endtask

  function automatic logic [23:0] pix_at(input int mode, input int x, input int y);
    case (mode)
      1: return (x == 5 && y == 3) ? 24'hC80000 : 24'h000000;
      2: return ((x == 2 && y == 1) || (x == 10 && y == 6)) ? 24'h009600 : 24'h006300;
      3: return {8'(x * 7 + 1), 8'(y * 9 + 2), 8'(x + y)};
      4: return (x == 3 && y == 2) ? 24'h000096 : 24'h969663;
      5: return (x == 2053) ? 24'h000096 : 24'h000000;
      6: return 24'hC80000;
      default: return 24'h000000;
    endcase
  endfunction

  function automatic bit hit(input int x, input int y);
    bit ix, iy, h;
    ix = (x >= mx0) && (x <= mx1);
    iy = (y >= my0) && (y <= my1);
    h  = ((x == mx0 || x == mx1) && iy) || ((y == my0 || y == my1) && ix);
`ifdef VP_BBOX_CENTROID_EN
    h  = h || (ix && iy && (x == mcx || y == mcy));
`endif
    return h;
  endfunction

  task automatic lines(input int w, input int h, input int mode);
    logic [23:0] p;
    for (int y = 0; y < h; y++) begin
      for (int x = 0; x < w; x++) begin
        p = pix_at(mode, x, y);
        drive(1'b1, 1'b0, 1'b0, p, (ovl_model && hit(x, y)) ? OVL : p);
      end
      for (int i = 0; i < 6; i++) drive(1'b0, (i == 2 || i == 3), 1'b0, BLANK, BLANK);
    end
  endtask

  task automatic vsync_pulse();
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b1, BLANK, BLANK);
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 1'b0, BLANK, BLANK);
  endtask

  // Expected snapshot values of -1 mean no bbox_valid pulse may occur.
  task automatic check_close(input string tag, input int n, input int xa, input int xb,
                             input int ya, input int yb, input int emp,
                             input int ecx, input int ecy);
    int v0;
    v0 = valid_cnt;
    s_xmin = -1; s_xmax = -1; s_ymin = -1; s_ymax = -1; s_empty = -1; s_cx = -1; s_cy = -1;
    vsync_pulse();
    chk({tag, "_valid_pulses"}, valid_cnt - v0, n);
    chk({tag, "_x_min"}, s_xmin, xa);
    chk({tag, "_x_max"}, s_xmax, xb);
    chk({tag, "_y_min"}, s_ymin, ya);
    chk({tag, "_y_max"}, s_ymax, yb);
    chk({tag, "_empty"}, s_empty, emp);
`ifdef VP_BBOX_CENTROID_EN
    chk({tag, "_cx"}, s_cx, ecx);
    chk({tag, "_cy"}, s_cy, ecy);
`endif
  endtask

  initial begin
    thr = 8'd128;
    sw  = 3'b000;
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b1, 24'hFFFFFF, 24'h0);
    chk("rst_de_out", de_out, 0);
    chk("rst_hs_out", h_sync_out, 0);
    chk("rst_vs_out", v_sync_out, 0);
    chk("rst_pixel_out", pixel_out, 0);
    chk("rst_valid", bbox_valid, 0);
    chk("rst_empty", bbox_empty, 1);
    chk("rst_box", {x_min, x_max, y_min, y_max}, 0);

    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b0, BLANK, BLANK);
    pipe_on = 1;

    // Partial frame after reset: all foreground, must be discarded.
    lines(16, 3, 6);
    check_close("t1_first", 0, -1, -1, -1, -1, -1, -1, -1);
    chk("t1_first_empty_held", bbox_empty, 1);
    lines(16, 8, 1);
    check_close("t1_f1", 1, 5, 5, 3, 3, 0, 5, 3);
    lines(16, 8, 1);
    check_close("t1_f2", 1, 5, 5, 3, 3, 0, 5, 3);

    thr = 8'd1;
    lines(16, 8, 0);
    check_close("t2_empty", 1, 0, 0, 0, 0, 1, 0, 0);

    thr = 8'd100;
    sw  = 3'b001;
    lines(16, 8, 2);
    check_close("t3_green", 1, 2, 10, 1, 6, 0, 6, 3);
    sw = 3'b000;
    lines(16, 8, 2);
    check_close("t3_red", 1, 0, 0, 0, 0, 1, 0, 0);
    sw = 3'b001;
    lines(16, 8, 2);
    check_close("t4_n", 1, 2, 10, 1, 6, 0, 6, 3);

    // Overlay of box (2,10,1,6) on a varied frame; red >= 100 only at column 15.
    sw = 3'b100;
    ovl_model = 1;
    lines(16, 8, 3);
    ovl_model = 0;
    check_close("t4_n1", 1, 15, 15, 0, 7, 0, 15, 3);

    sw = 3'b011;
    lines(16, 8, 4);
    check_close("t5_sel3", 1, 3, 3, 2, 2, 0, 3, 2);
    sw = 3'b010;
    lines(16, 8, 4);
    check_close("t5_sel2", 1, 3, 3, 2, 2, 0, 3, 2);
    lines(2060, 1, 5);
    check_close("t5_sat", 1, 2047, 2047, 0, 0, 0, 2047, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
